// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause codes, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_EXT  = 2'd0;
  localparam logic [1:0] CAUSE_SOFT = 2'd1;
  localparam logic [1:0] CAUSE_WDT  = 2'd2;

  // One extra bit over the largest terminal count so no counter can wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// Watchdog for the reset sequencer: counts RUN cycles without a kick, flags timeout.
// Latency: timeout is combinational on the WDT_TIMEOUT-th unkicked RUN edge; the parent registers it.
// Backpressure: none; a kick on the final edge suppresses the timeout. Built only with RST_SEQ_WDT_EN.
module rst_seq_wdt
  import rst_seq_pkg::*;
#(
  parameter int WDT_TIMEOUT = 64,
  parameter int CW          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic timeout
);

  logic [CW-1:0] wcnt;

  assign timeout = run && !kick && (wcnt == CW'(WDT_TIMEOUT - 1));

  // Count unkicked RUN edges; any kick, leaving RUN or a timeout starts over from zero.
  always_ff @(posedge clk) begin
    if (rst || !run || kick || timeout) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + CW'(1);
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains, releases them in ascending order, tracks reset cause (watchdog with RST_SEQ_WDT_EN).
// Latency: domain 0 released HOLD_CYCLES edges after a reset event, each further domain STAGE_GAP edges later.
// Backpressure: none; soft_rst_req (or watchdog timeout) restarts the sequence from the edge it is sampled on.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst_req,
  input  logic             wdt_kick,
  output logic [N_DOM-1:0] rst_out,
  output logic             seq_done,
  output logic [1:0]       rst_cause
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, WDT_TIMEOUT);
  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DOM - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [N_DOM-1:0] rst_out_nxt;
  logic             seq_done_nxt;
  logic [1:0]       rst_cause_nxt;
  logic             in_run;
  logic             wdt_to;

  assign in_run = (state == RUN);

`ifdef RST_SEQ_WDT_EN
  rst_seq_wdt #(
    .WDT_TIMEOUT(WDT_TIMEOUT),
    .CW         (CW)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .run    (in_run),
    .kick   (wdt_kick),
    .timeout(wdt_to)
  );
`else
  // Port kept so the parent wiring is identical in both builds.
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_to          = 1'b0;
`endif

  // Next-state and next-output logic; a reset event overrides whatever the FSM was doing.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    rst_out_nxt   = rst_out;
    seq_done_nxt  = seq_done;
    rst_cause_nxt = rst_cause;
    if (soft_rst_req || wdt_to) begin
      state_nxt     = HOLD;
      cnt_nxt       = '0;
      idx_nxt       = '0;
      rst_out_nxt   = '1;
      seq_done_nxt  = 1'b0;
      rst_cause_nxt = soft_rst_req ? CAUSE_SOFT : CAUSE_WDT;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt_nxt        = '0;
            rst_out_nxt[0] = 1'b0;
            if (N_DOM == 1) begin
              state_nxt    = RUN;
              seq_done_nxt = 1'b1;
            end else begin
              idx_nxt   = IW'(1);
              state_nxt = RELEASE;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == CW'(STAGE_GAP - 1)) begin
            cnt_nxt = '0;
            for (int k = 0; k < N_DOM; k++) begin
              if (IW'(k) == idx) rst_out_nxt[k] = 1'b0;
            end
            if (idx == LAST_IDX) begin
              state_nxt    = RUN;
              seq_done_nxt = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        RUN: begin
          rst_out_nxt  = '0;
          seq_done_nxt = 1'b1;
        end
        default: begin
          state_nxt = HOLD;
        end
      endcase
    end
  end

  // State and output registers; master reset forces everything back to the held state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      seq_done  <= 1'b0;
      rst_cause <= CAUSE_EXT;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      rst_out   <= rst_out_nxt;
      seq_done  <= seq_done_nxt;
      rst_cause <= rst_cause_nxt;
    end
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer between the board-level clock/reset source and the CPU `top`. It holds every reset domain of the core in reset for a programmable number of cycles, then releases the domains one at a time in a fixed order. It also accepts a software reset request and, optionally, a watchdog timeout, and records the cause of the most recent reset.

## Interface
Parameters:
- `N_DOM`, default 3: number of reset domains; domain 0 is released first. Legal range is ≥1.
- `HOLD_CYCLES`, default 16: cycles that all domains stay asserted before release starts. Legal range is ≥1.
- `STAGE_GAP`, default 4: cycles between consecutive domain releases. Legal range is ≥1.
- `WDT_TIMEOUT`, default 64: cycles without a kick in RUN before a watchdog reset. Used only when `RST_SEQ_WDT_EN` is defined.

Ports:
- `clk` in, 1: single clock.
- `rst` in, 1: synchronous, active-high master reset.
- `soft_rst_req` in, 1: single-cycle software reset request.
- `wdt_kick` in, 1: watchdog service pulse. Ignored when the watchdog is compiled out.
- `rst_out` out, `N_DOM`: per-domain reset, active-high.
- `seq_done` out, 1: high while every domain is released.
- `rst_cause` out, 2: cause of the last reset. 0 = master reset, 1 = soft reset, 2 = watchdog.

## Operation
- The FSM has three states: HOLD, RELEASE and RUN. One counter `cnt` and one stage index `idx` are shared between states.
- Values while `rst` is high (on every edge):
  - state = HOLD, `cnt` = 0, `idx` = 0
  - `rst_out` = all ones, `seq_done` = 0, `rst_cause` = 0
  - watchdog counter = 0
- HOLD state:
  - `cnt` increments on every edge.
  - On the edge where `cnt == HOLD_CYCLES-1`:
    - clear `rst_out[0]` and reset `cnt` to 0;
    - if `N_DOM == 1`, go to RUN and set `seq_done`;
    - otherwise set `idx` = 1 and go to RELEASE.
- RELEASE state:
  - `cnt` increments on every edge.
  - On the edge where `cnt == STAGE_GAP-1`:
    - clear `rst_out[idx]` and reset `cnt` to 0;
    - if `idx == N_DOM-1`, go to RUN and set `seq_done` on the same edge;
    - otherwise increment `idx`.
- RUN state: `rst_out` = 0 and `seq_done` = 1.
- A reset event is either `soft_rst_req` (in any state) or a watchdog timeout (RUN only). On a reset event the next edge does all of the following:
  - `rst_out` = all ones, `seq_done` = 0;
  - `cnt` = 0, `idx` = 0, state = HOLD;
  - `rst_cause` is updated.
- `soft_rst_req` during HOLD restarts the hold count.
- `rst_cause` is sticky until the next reset event.
- Priority:
  - `rst` beats everything.
  - If `soft_rst_req` and a watchdog timeout occur on the same edge, `rst_cause` = 1.
- The release order is strictly ascending. A domain with a higher index is never released before a domain with a lower index.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Edge 1 is the first rising edge with `rst` low. With default parameters:
  - `rst_out[0]` falls at edge `HOLD_CYCLES` (16);
  - `rst_out[k]` falls at edge `HOLD_CYCLES + k*STAGE_GAP` (20, then 24);
  - `seq_done` rises at edge 24.
- A reset event sampled at edge t gives `rst_out` = all ones at t and restarts the sequence from t. The first domain is released at edge t + `HOLD_CYCLES`.
- Watchdog timing:
  - The watchdog counter counts only in RUN. It clears on `wdt_kick` and on leaving RUN.
  - A timeout occurs on the `WDT_TIMEOUT`-th consecutive RUN edge without a kick.
  - If a kick and the final count land on the same edge, the kick wins and there is no timeout.
- Counter widths are `$clog2` of the largest of `HOLD_CYCLES`, `STAGE_GAP` and `WDT_TIMEOUT`, plus 1. Counters never wrap.

## Configuration
- Macro: `RST_SEQ_WDT_EN`.
- When defined:
  - the watchdog counter and timeout reset are present;
  - `rst_cause` can take the value 2.
- When undefined:
  - no watchdog logic is built;
  - `wdt_kick` is left unconnected inside the block but the port remains, so the `top` wiring is the same in both builds;
  - `rst_cause` can only be 0 or 1.

## Structure
- `rst_seq_pkg` contains:
  - the FSM state enum (HOLD, RELEASE, RUN);
  - the `rst_cause` encodings `CAUSE_EXT`, `CAUSE_SOFT` and `CAUSE_WDT`.
- Sub-module `rst_seq_wdt` contains the watchdog counter and timeout compare. It is instantiated only under `RST_SEQ_WDT_EN`.

## Test plan
- Power-on with defaults: hold `rst` high for 3 edges, then release → `rst_out` = 3'b111 through edge 15, 3'b110 at edge 16, 3'b100 at edge 20, 3'b000 at edge 24, `seq_done` = 1 at edge 24, `rst_cause` = 0.
- Soft reset in RUN: pulse `soft_rst_req` at edge 40 → `rst_out` = 3'b111 and `seq_done` = 0 at edge 40, `rst_out[0]` falls at edge 56, `seq_done` = 1 at edge 64, `rst_cause` = 1.
- Soft reset during RELEASE: pulse at edge 18 → all domains re-asserted at edge 18, and the full sequence replays from edge 18.
- Master reset mid-RELEASE: drive `rst` high at edge 21 → at edge 21 all outputs return to their reset values, including `rst_cause` = 0.
- Watchdog (`RST_SEQ_WDT_EN` defined): no kick after entering RUN at edge 24 → timeout at edge 88 and `rst_cause` = 2. A kick every 50 cycles → no timeout. A soft reset on the timeout edge → `rst_cause` = 1.
- `N_DOM` = 1, `HOLD_CYCLES` = 1: `rst_out` falls and `seq_done` rises together at edge 1.
